// File: rtl/pdm_capture.sv
// pdm_capture: PDM microphone front end.
// Divides the system clock down to the PDM bit clock, samples the shared data
// line on the falling (left) and optionally the rising (right) PDM clock edges.
// Bits are packed MSB-first into WORD_WIDTH words, which are buffered in a
// show-ahead FIFO with a valid/ready output handshake.
// Build option: define PDM_CAPTURE_STEREO_EN to add the right-channel path
// (sampled on 0->1 edges); without it only left words are produced.
module pdm_capture #(
  parameter int WORD_WIDTH  = 16,
  parameter int HALF_PERIOD = 50,
  parameter int FIFO_DEPTH  = 8
) (
  input  logic                              clock_i,
  input  logic                              reset_i,
  input  logic                              enable_i,
  output logic                              pdm_clk_o,
  input  logic                              pdm_data_i,
  output logic                              pdm_lrsel_o,
  output logic [WORD_WIDTH-1:0]             data_o,
  output logic                              channel_o,
  output logic                              valid_o,
  input  logic                              ready_i,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   count_o,
  output logic                              overflow_o
);

`ifdef PDM_CAPTURE_STEREO_EN
  localparam int NUM_CH = 2;
`else
  localparam int NUM_CH = 1;
`endif
  localparam int DIV_W = $clog2(HALF_PERIOD);
  localparam int BIT_W = $clog2(WORD_WIDTH);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH+1);

  // ---------------------------------------------------------------- divider
  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic             pdm_clk_q, pdm_clk_d;
  logic             div_wrap;
  logic             left_evt;

  assign div_wrap = enable_i && (div_cnt_q == DIV_W'(HALF_PERIOD-1));
  // Left data is valid at the end of the high phase (clock about to fall).
  assign left_evt = div_wrap && pdm_clk_q;

  // Half-period counter; toggles the PDM clock on wrap, parks low when idle.
  always_comb begin
    div_cnt_d = div_cnt_q;
    pdm_clk_d = pdm_clk_q;
    if (!enable_i) begin
      div_cnt_d = '0;
      pdm_clk_d = 1'b0;
    end else if (div_wrap) begin
      div_cnt_d = '0;
      pdm_clk_d = ~pdm_clk_q;
    end else begin
      div_cnt_d = div_cnt_q + DIV_W'(1);
    end
  end

  // Divider state register.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      div_cnt_q <= '0;
      pdm_clk_q <= 1'b0;
    end else begin
      div_cnt_q <= div_cnt_d;
      pdm_clk_q <= pdm_clk_d;
    end
  end

  assign pdm_clk_o   = pdm_clk_q;
  assign pdm_lrsel_o = 1'b0;

  // ---------------------------------------------------------------- packing
  logic [NUM_CH-1:0]                 sample_evt;
  logic [NUM_CH-1:0]                 word_done;
  logic [NUM_CH-1:0][WORD_WIDTH-1:0] word_data;

`ifdef PDM_CAPTURE_STEREO_EN
  logic right_evt;
  // Right data is valid at the end of the low phase (clock about to rise).
  assign right_evt  = div_wrap && !pdm_clk_q;
  assign sample_evt = {right_evt, left_evt};
`else
  assign sample_evt = left_evt;
`endif

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_chan
      logic [WORD_WIDTH-1:0] shift_q, shift_d;
      logic [BIT_W-1:0]      bits_q, bits_d;
      logic                  done;

      // Shift the sampled bit in at the LSB; flag the word on its last bit.
      always_comb begin
        shift_d = shift_q;
        bits_d  = bits_q;
        done    = 1'b0;
        if (!enable_i) begin
          shift_d = '0;
          bits_d  = '0;
        end else if (sample_evt[gi]) begin
          shift_d = {shift_q[WORD_WIDTH-2:0], pdm_data_i};
          if (bits_q == BIT_W'(WORD_WIDTH-1)) begin
            bits_d = '0;
            done   = 1'b1;
          end else begin
            bits_d = bits_q + BIT_W'(1);
          end
        end
      end

      // Per-channel packing registers.
      always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
          shift_q <= '0;
          bits_q  <= '0;
        end else begin
          shift_q <= shift_d;
          bits_q  <= bits_d;
        end
      end

      assign word_done[gi] = done;
      assign word_data[gi] = shift_d;
    end
  endgenerate

  // ---------------------------------------------------------------- FIFO
  logic                  push_req, push_ok, pop, full, drop;
  logic [WORD_WIDTH-1:0] push_data;
  logic                  push_ch;
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic                  overflow_q, overflow_d;
  logic [WORD_WIDTH-1:0] data_mem [FIFO_DEPTH];

  // Left and right samples never coincide, so at most one word per cycle.
  assign push_req = |word_done;
`ifdef PDM_CAPTURE_STEREO_EN
  assign push_ch   = word_done[1];
  assign push_data = word_done[1] ? word_data[1] : word_data[0];
`else
  assign push_ch   = 1'b0;
  assign push_data = word_data[0];
`endif

  assign valid_o = (count_q != '0);
  assign full    = (count_q == CNT_W'(FIFO_DEPTH));
  assign pop     = valid_o && ready_i;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign push_ok = push_req && (!full || pop);
  assign drop    = push_req && full && !pop;

  // Pointer/occupancy update and sticky overflow.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q | drop;
    if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)     rd_ptr_d = rd_ptr_q + PTR_W'(1);
    if (push_ok && !pop)      count_d = count_q + CNT_W'(1);
    else if (pop && !push_ok) count_d = count_q - CNT_W'(1);
  end

  // FIFO control registers.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Word storage; contents are only visible while the FIFO is non-empty.
  always_ff @(posedge clock_i) begin
    if (push_ok) data_mem[wr_ptr_q] <= push_data;
  end

  assign data_o     = valid_o ? data_mem[rd_ptr_q] : '0;
  assign count_o    = count_q;
  assign overflow_o = overflow_q;

`ifdef PDM_CAPTURE_STEREO_EN
  logic ch_mem [FIFO_DEPTH];

  // Source channel of each stored word.
  always_ff @(posedge clock_i) begin
    if (push_ok) ch_mem[wr_ptr_q] <= push_ch;
  end

  assign channel_o = valid_o ? ch_mem[rd_ptr_q] : 1'b0;
`else
  assign channel_o = push_ch;
`endif

endmodule
